// File: rtl/avg_hold_accumulator.sv
// avg_hold_accumulator: measurement hold / averaging controller for a display path.
//
// Four-state FSM (Meas, Hold, Acq, Average). In Meas the display follows the ADC.
// In manual mode each hold press adds one sample to a running sum and freezes the
// display on it. In auto mode a press starts a burst that collects N = 2**LOG2_N
// valid samples. Once N samples are summed, the display shows their truncated mean.
// All outputs are registered.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   clear          in   synchronous abort/clear, highest priority
//   hold_tick      in   one-cycle hold-press pulse
//   release_tick   in   one-cycle release-press pulse
//   auto_mode      in   0 = manual (one sample per press), 1 = burst of N samples
//   meas_valid     in   meas_value carries a new conversion this cycle
//   meas_value     in   unsigned ADC sample, DATA_W bits
//   display_value  out  value for the display path, DATA_W bits
//   acumul_value   out  running sum, DATA_W+LOG2_N bits
//   sample_count   out  samples accumulated in the current group, LOG2_N bits
//   average_enable out  display_value is an average
//   LED_hold       out  high in Hold or Acq
//   LED_average    out  high in Average

module avg_hold_accumulator #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned LOG2_N = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     hold_tick,
    input  logic                     release_tick,
    input  logic                     auto_mode,
    input  logic                     meas_valid,
    input  logic [DATA_W-1:0]        meas_value,
    output logic [DATA_W-1:0]        display_value,
    output logic [DATA_W+LOG2_N-1:0] acumul_value,
    output logic [LOG2_N-1:0]        sample_count,
    output logic                     average_enable,
    output logic                     LED_hold,
    output logic                     LED_average
);

    // The sum is wide enough to hold N full-scale samples, so it never overflows.
    localparam int unsigned SUM_W = DATA_W + LOG2_N;

    typedef enum logic [1:0] {
        StMeas    = 2'd0,
        StHold    = 2'd1,
        StAcq     = 2'd2,
        StAverage = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   display_q, display_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [LOG2_N-1:0]   count_q, count_d;
    logic                avg_en_q, avg_en_d;
    logic                led_hold_q, led_hold_d;
    logic                led_avg_q, led_avg_d;

    logic [SUM_W-1:0]    sum_add;
    logic [DATA_W-1:0]   avg_of_add;
    logic                last_sample;

    // Sum including the current sample. Its truncated mean is the upper DATA_W bits.
    assign sum_add     = sum_q + SUM_W'(meas_value);
    assign avg_of_add  = sum_add[SUM_W-1:LOG2_N];
    // The count is LOG2_N bits wide, so N-1 is all ones and the increment wraps to 0.
    assign last_sample = (count_q == '1);

    always_comb begin
        state_d    = state_q;
        display_d  = display_q;
        sum_d      = sum_q;
        count_d    = count_q;
        avg_en_d   = avg_en_q;
        led_hold_d = led_hold_q;
        led_avg_d  = led_avg_q;

        unique case (state_q)
            StMeas: begin
                if (hold_tick) begin
                    if (!auto_mode) begin
                        sum_d   = sum_add;
                        count_d = count_q + LOG2_N'(1);
                        if (last_sample) begin
                            state_d   = StAverage;
                            display_d = avg_of_add;
                            avg_en_d  = 1'b1;
                            led_avg_d = 1'b1;
                        end else begin
                            state_d    = StHold;
                            display_d  = meas_value;
                            led_hold_d = 1'b1;
                        end
                    end else begin
                        // A burst always starts from an empty group. Any partial
                        // manual sum is dropped. The display keeps its last value.
                        state_d    = StAcq;
                        sum_d      = '0;
                        count_d    = '0;
                        led_hold_d = 1'b1;
                    end
                end else if (meas_valid) begin
                    display_d = meas_value;
                end
            end

            StHold: begin
                // The partial group is kept so that later presses continue it.
                if (release_tick) begin
                    state_d    = StMeas;
                    led_hold_d = 1'b0;
                end
            end

            StAcq: begin
                // An abort wins over a sample that arrives in the same cycle.
                if (release_tick) begin
                    state_d    = StMeas;
                    sum_d      = '0;
                    count_d    = '0;
                    led_hold_d = 1'b0;
                end else if (meas_valid) begin
                    sum_d   = sum_add;
                    count_d = count_q + LOG2_N'(1);
                    if (last_sample) begin
                        state_d    = StAverage;
                        display_d  = avg_of_add;
                        avg_en_d   = 1'b1;
                        led_avg_d  = 1'b1;
                        led_hold_d = 1'b0;
                    end
                end
            end

            StAverage: begin
                if (release_tick) begin
                    state_d   = StMeas;
                    sum_d     = '0;
                    count_d   = '0;
                    avg_en_d  = 1'b0;
                    led_avg_d = 1'b0;
                end
            end

            default: begin
                state_d = StMeas;
            end
        endcase

        if (clear) begin
            state_d    = StMeas;
            display_d  = '0;
            sum_d      = '0;
            count_d    = '0;
            avg_en_d   = 1'b0;
            led_hold_d = 1'b0;
            led_avg_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StMeas;
            display_q  <= '0;
            sum_q      <= '0;
            count_q    <= '0;
            avg_en_q   <= 1'b0;
            led_hold_q <= 1'b0;
            led_avg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            display_q  <= display_d;
            sum_q      <= sum_d;
            count_q    <= count_d;
            avg_en_q   <= avg_en_d;
            led_hold_q <= led_hold_d;
            led_avg_q  <= led_avg_d;
        end
    end

    assign display_value  = display_q;
    assign acumul_value   = sum_q;
    assign sample_count   = count_q;
    assign average_enable = avg_en_q;
    assign LED_hold       = led_hold_q;
    assign LED_average    = led_avg_q;

endmodule

// File: doc/avg_hold_accumulator.md
AVG_HOLD_ACCUMULATOR -- requirements
Module: avg_hold_accumulator

Interface
REQ-001 Parameter DATA_W, default 12: measurement sample width in bits, legal range 4..16.
REQ-002 Parameter LOG2_N, default 2: averaging depth is N = 2**LOG2_N samples, legal range 1..6.
REQ-003 Parameter SUM_W = DATA_W+LOG2_N is derived and SHALL NOT be overridden.
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL change on its rising edge only.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port clear, input, 1 bit: synchronous abort/clear.
REQ-007 Port hold_tick, input, 1 bit: one-cycle hold-press pulse.
REQ-008 Port release_tick, input, 1 bit: one-cycle release-press pulse.
REQ-009 Port auto_mode, input, 1 bit: 0 = manual (one sample per press); 1 = automatic burst of N samples.
REQ-010 Port meas_valid, input, 1 bit: meas_value holds a new conversion this cycle.
REQ-011 Port meas_value, input, DATA_W bits: unsigned ADC sample.
REQ-012 Port display_value, output, DATA_W bits: value for the display path.
REQ-013 Port acumul_value, output, SUM_W bits: running sum.
REQ-014 Port sample_count, output, LOG2_N bits: samples accumulated in the current group.
REQ-015 Port average_enable, output, 1 bit: display_value is an average.
REQ-016 Port LED_hold, output, 1 bit: high in HOLD or ACQ.
REQ-017 Port LED_average, output, 1 bit: high in AVERAGE.

Function
REQ-018 The FSM SHALL have four states: MEAS, HOLD, ACQ, AVERAGE; all outputs SHALL be registered.
REQ-019 clear SHALL have the highest priority: next state MEAS, and all outputs and counters SHALL take their reset values.
REQ-020 MEAS: display_value SHALL load meas_value on every meas_valid cycle (1-cycle latency).
REQ-021 MEAS with hold_tick and auto_mode=0: acumul_value += meas_value and sample_count += 1.
REQ-022 Under REQ-021, if sample_count was N-1, the FSM SHALL go to AVERAGE; otherwise it SHALL go to HOLD with display_value = meas_value.
REQ-023 MEAS with hold_tick and auto_mode=1: acumul_value and sample_count SHALL clear, display_value SHALL freeze, and the FSM SHALL go to ACQ.
REQ-024 ACQ: each meas_valid SHALL add meas_value to the sum and increment sample_count; the Nth sample SHALL enter AVERAGE in the same edge.
REQ-025 On entry to AVERAGE, display_value SHALL equal (final sum) >> LOG2_N, truncated; average_enable = LED_average = 1, LED_hold = 0, and sample_count wraps to 0.
REQ-026 HOLD with release_tick: the FSM SHALL return to MEAS and LED_hold = 0; the partial sum and sample_count SHALL be retained.
REQ-027 ACQ with release_tick: the burst SHALL abort, the sum and count SHALL clear, and the FSM SHALL return to MEAS.
REQ-028 AVERAGE with release_tick: the FSM SHALL return to MEAS with the sum, count, average_enable and LED_average cleared.
REQ-029 hold_tick SHALL be ignored in HOLD, ACQ and AVERAGE; release_tick SHALL be ignored in MEAS.
REQ-030 Simultaneous hold_tick and release_tick SHALL act per REQ-029, so only the event legal in the current state takes effect.
REQ-031 In ACQ, release_tick SHALL take priority over meas_valid in the same cycle.
REQ-032 auto_mode SHALL be sampled only on a MEAS hold_tick.
REQ-033 Changing auto_mode with a partial manual sum pending SHALL discard that sum on the next hold_tick in auto mode.
REQ-034 The sum SHALL never overflow, since SUM_W bits hold N*(2**DATA_W - 1).

Reset
REQ-035 While rst_n = 0, all outputs SHALL be zero and the state SHALL be MEAS, independent of clk.
REQ-036 Reset asserted mid-HOLD, ACQ or AVERAGE SHALL discard all partial data.
REQ-037 The first edge after rst_n deasserts SHALL behave as a normal MEAS cycle.

Verification
REQ-038 Scenario: defaults, manual mode, samples 100/200/300/400, each press followed by release -> HOLD shows 100, 200, 300; the 4th press gives AVERAGE, display_value = 250, acumul_value = 1000.
REQ-039 Scenario: defaults, auto mode, hold_tick then valid samples 4095 x4 -> ACQ, then AVERAGE with display_value = 4095 and acumul_value = 16380; LED_average = 1 exactly one cycle after the 4th sample.
REQ-040 Scenario: truncation, manual samples 1/1/1/2 -> display_value = 1 (5 >> 2).
REQ-041 Scenario: auto burst with release_tick and meas_valid together after 2 samples -> MEAS, acumul_value = 0, sample_count = 0.
REQ-042 Scenario: rst_n low mid-ACQ with no clk edge -> all outputs 0 immediately; clear in AVERAGE -> MEAS next cycle.
REQ-043 Scenario: LOG2_N = 3, DATA_W = 16, auto mode, 8 samples of 65535 -> acumul_value = 524280, display_value = 65535.
